// File: rtl/fp_sub_pipe.sv
// Pipelined diff = a - b on a {sign,exp,frac} float, truncating, no special values; 3 cycles accept -> out_valid.
// Stalls on held output; FP_SUB_PIPE_SKID_EN adds a 2-entry output skid buffer and a registered in_ready.
module fp_sub_pipe #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   localparam int WIDTH = 1 + EXP_W + FRAC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             ovf
);
   localparam int MW   = FRAC_W + 1;
   localparam int EMAX = (1 << EXP_W) - 1;

   logic adv;

   logic             s0_valid;
   logic [WIDTH-1:0] s0_a, s0_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_a     <= '0;
         s0_b     <= '0;
      end else if (adv) begin
         s0_valid <= in_valid && in_ready;
         if (in_valid && in_ready) begin
            s0_a <= a;
            s0_b <= b;
         end
      end
   end

   // Swap so X has the larger magnitude, then align Y to X's exponent.
   logic [WIDTH-1:0] bn, x, y;
   logic [EXP_W-1:0] x_exp, y_exp, x_eff, y_eff, sh;
   logic [MW-1:0]    x_man, y_man, y_al;

   always_comb begin
      bn = {~s0_b[WIDTH-1], s0_b[WIDTH-2:0]};
      x  = s0_a;
      y  = bn;
      if (bn[WIDTH-2:0] > s0_a[WIDTH-2:0]) begin
         x = bn;
         y = s0_a;
      end
      x_exp = x[WIDTH-2:FRAC_W];
      y_exp = y[WIDTH-2:FRAC_W];
      x_eff = (x_exp == '0) ? EXP_W'(1) : x_exp;
      y_eff = (y_exp == '0) ? EXP_W'(1) : y_exp;
      x_man = {x_exp != '0, x[FRAC_W-1:0]};
      y_man = {y_exp != '0, y[FRAC_W-1:0]};
      sh    = x_eff - y_eff;
      y_al  = (32'(sh) >= 32'(MW)) ? '0 : (y_man >> sh);
   end

   logic             s1_valid, s1_sign, s1_sub;
   logic [EXP_W-1:0] s1_exp;
   logic [MW-1:0]    s1_mx, s1_my;
   logic             s2_valid, s2_sign;
   logic [EXP_W-1:0] s2_exp;
   logic [MW:0]      s2_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_sub   <= 1'b0;
         s1_exp   <= '0;
         s1_mx    <= '0;
         s1_my    <= '0;
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_exp   <= '0;
         s2_sum   <= '0;
      end else if (adv) begin
         s1_valid <= s0_valid;
         s1_sign  <= x[WIDTH-1];
         s1_sub   <= x[WIDTH-1] != y[WIDTH-1];
         s1_exp   <= x_eff;
         s1_mx    <= x_man;
         s1_my    <= y_al;
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_exp   <= s1_exp;
         s2_sum   <= s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my})
                            : ({1'b0, s1_mx} + {1'b0, s1_my});
      end
   end

   // Normalise: the left shift stops at exponent 1, below which the result is subnormal.
   logic [31:0]      lz, e32, e_res;
   logic [MW:0]      norm;
   logic             n_ovf;
   logic [WIDTH-1:0] n_diff;
   logic             unused_bits;

   always_comb begin
      lz = 32'(MW);
      for (int i = 0; i <= FRAC_W; i++) begin
         if (s2_sum[i]) lz = 32'(FRAC_W - i);
      end
      e32   = {{(32-EXP_W){1'b0}}, s2_exp};
      norm  = s2_sum;
      e_res = e32;
      if (s2_sum[MW]) begin
         norm  = s2_sum >> 1;
         e_res = e32 + 32'd1;
      end else if (lz <= e32 - 32'd1) begin
         norm  = s2_sum << lz;
         e_res = e32 - lz;
      end else begin
         norm  = s2_sum << (e32 - 32'd1);
         e_res = '0;
      end
      n_ovf = (s2_sum != '0) && (e_res >= 32'(EMAX));
      if (s2_sum == '0)
         n_diff = '0;
      else if (n_ovf)
         n_diff = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else
         n_diff = {s2_sign, e_res[EXP_W-1:0], norm[FRAC_W-1:0]};
   end

   assign unused_bits = ^norm[MW:FRAC_W];

   logic             s3_valid, s3_ovf;
   logic [WIDTH-1:0] s3_diff;

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid <= 1'b0;
         s3_diff  <= '0;
         s3_ovf   <= 1'b0;
      end else if (adv) begin
         s3_valid <= s2_valid;
         if (s2_valid) begin
            s3_diff <= n_diff;
            s3_ovf  <= n_ovf;
         end
      end
   end

`ifdef FP_SUB_PIPE_SKID_EN
   // Stage 3 drains into the skid whenever it is not handed straight to the consumer.
   logic [1:0]   q_cnt, q_cnt_nx;
   logic [WIDTH:0] q0, q1;
   logic         push, popq;

   always_comb begin
      popq     = (q_cnt != 2'd0) && out_ready;
      adv      = !s3_valid || out_ready || (q_cnt != 2'd2);
      push     = s3_valid && adv && !((q_cnt == 2'd0) && out_ready);
      q_cnt_nx = q_cnt + {1'b0, push} - {1'b0, popq};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_cnt    <= 2'd0;
         q0       <= '0;
         q1       <= '0;
         in_ready <= 1'b1;
      end else begin
         q_cnt    <= q_cnt_nx;
         in_ready <= q_cnt_nx != 2'd2;
         if (popq) q0 <= q1;
         if (push && (q_cnt_nx == 2'd1)) q0 <= {s3_ovf, s3_diff};
         if (push && (q_cnt_nx == 2'd2)) q1 <= {s3_ovf, s3_diff};
      end
   end

   assign out_valid = s3_valid || (q_cnt != 2'd0);
   assign diff      = (q_cnt != 2'd0) ? q0[WIDTH-1:0] : s3_diff;
   assign ovf       = (q_cnt != 2'd0) ? q0[WIDTH]     : s3_ovf;
`else
   assign adv       = !s3_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = s3_valid;
   assign diff      = s3_diff;
   assign ovf       = s3_ovf;
`endif

endmodule

// File: tb/tb_fp_sub_pipe.sv
// Directed bench for fp_sub_pipe: vector results, latency, backpressure ordering and reset flush.
module tb_fp_sub_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        ovf;

   int checks = 0;
   int errors = 0;
   int tx, rx, stale;
   logic ir_a, ir_b;
   logic [31:0] kv [0:6];

   fp_sub_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One pair into an empty pipeline; result must appear 3 edges after accept.
   task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] expd, input logic expo);
      int lat;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_diff"}, diff, expd);
      chk({tag, "_ovf"}, 32'(ovf), 32'(expo));
      tick();
   endtask

   initial begin
      kv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000};
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", diff, 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      run_vec("three_minus_one", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0);
      run_vec("x_minus_x",       32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0);
      run_vec("negx_minus_negx", 32'hBF800000, 32'hBF800000, 32'h00000000, 1'b0);
      run_vec("one_minus_neg1",  32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0);
      run_vec("subnormal_res",   32'h00800000, 32'h00400000, 32'h00400000, 1'b0);
      run_vec("ulp_diff",        32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0);
      run_vec("overflow",        32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1);
      run_vec("neg_result",      32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0);
      run_vec("shift_24_zero",   32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
      run_vec("shift_23",        32'h3F800000, 32'h34000000, 32'h3F7FFFFE, 1'b0);
      run_vec("sub_plus_sub",    32'h00000001, 32'h80000001, 32'h00000002, 1'b0);
      run_vec("sub_to_normal",   32'h00400000, 32'h80400000, 32'h00800000, 1'b0);

      // Six back-to-back (k.0 - 1.0), consumer stalled on cycles 4..9.
      tx = 0;
      rx = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = !(cyc >= 4 && cyc <= 9);
         in_valid  = (tx < 6);
         a         = (tx < 6) ? kv[tx + 1] : 32'h0;
         b         = 32'h3F800000;
         #1;
`ifdef FP_SUB_PIPE_SKID_EN
         ir_a      = in_ready;
         out_ready = !out_ready;
         #1;
         ir_b      = in_ready;
         out_ready = !out_ready;
         #1;
         chk("bp_in_ready_indep", 32'(ir_b), 32'(ir_a));
`else
         ir_a = 1'b0;
         ir_b = 1'b0;
         if (out_valid && !out_ready) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
`endif
         if (out_valid && out_ready) begin
            if (rx < 6) chk("bp_out", diff, kv[rx]);
            else chk("bp_extra_output", 32'(rx), 32'd5);
            rx++;
         end
         if (in_valid && in_ready) tx++;
         tick();
      end
      chk("bp_accepted", 32'(tx), 32'd6);
      chk("bp_delivered", 32'(rx), 32'd6);
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Three pairs in flight, then a one-cycle reset.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = kv[i + 2];
         b        = kv[0];
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_diff", diff, 32'd0);
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) stale++;
         tick();
      end
      chk("flush_no_stale", 32'(stale), 32'd0);
      run_vec("post_reset", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
